// File: rtl/image_scanner.sv
// Read-side VGA scanner for the image store: 640x480@60 timing, incremental
// store addressing for a SCALE-magnified image, and a 2-stage colour pipeline.
module image_scanner #(
  parameter int          IMG_W    = 75,
  parameter int          IMG_H    = 75,
  parameter int          SCALE    = 4,
  parameter int          X0       = 170,
  parameter int          Y0       = 90,
  parameter logic [2:0]  BG_COLOR = 3'b000,
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  state,
  input  logic [2:0]  q,
  output logic [3:0]  image_state,
  output logic [18:0] address,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_END   = X0 + IMG_W * SCALE;
  localparam int Y_END   = Y0 + IMG_H * SCALE;

  logic [9:0]  h_r, v_r;
  logic [2:0]  sub_x_r, sub_y_r;
  logic [18:0] col_r, row_base_r;
  logic        hs_d_r, vs_d_r, active_d_r, in_image_d_r;
  logic        h_end_s, frame_end_s, in_x_s, in_y_s, in_image_s;
  logic        hs_s, vs_s, active_s;
  logic [2:0]  pix_s;

  assign h_end_s     = (int'(h_r) == H_TOTAL - 1);
  assign frame_end_s = h_end_s && (int'(v_r) == V_TOTAL - 1);
  assign in_x_s      = (int'(h_r) >= X0) && (int'(h_r) < X_END);
  assign in_y_s      = (int'(v_r) >= Y0) && (int'(v_r) < Y_END);
  assign in_image_s  = in_x_s && in_y_s;
  assign hs_s        = !((int'(h_r) >= H_ACTIVE + H_FP) && (int'(h_r) < H_ACTIVE + H_FP + H_SYNC));
  assign vs_s        = !((int'(v_r) >= V_ACTIVE + V_FP) && (int'(v_r) < V_ACTIVE + V_FP + V_SYNC));
  assign active_s    = (int'(h_r) < H_ACTIVE) && (int'(v_r) < V_ACTIVE);

  // Raster counters and the once-per-frame image select latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_r         <= 10'd0;
      v_r         <= 10'd0;
      image_state <= 4'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end_s;
      if (frame_end_s) begin
        image_state <= state;
      end
      if (h_end_s) begin
        h_r <= 10'd0;
        v_r <= (int'(v_r) == V_TOTAL - 1) ? 10'd0 : v_r + 10'd1;
      end else begin
        h_r <= h_r + 10'd1;
      end
    end
  end

  // Column tracking: sub_x divides h by SCALE without a divider.
  always_ff @(posedge clock) begin
    if (reset || h_end_s) begin
      sub_x_r <= 3'd0;
      col_r   <= 19'd0;
    end else if (in_x_s) begin
      if (sub_x_r == 3'(SCALE - 1)) begin
        sub_x_r <= 3'd0;
        col_r   <= col_r + 19'd1;
      end else begin
        sub_x_r <= sub_x_r + 3'd1;
      end
    end
  end

  // Row tracking: advance at end of each image line, step row_base by IMG_W.
  always_ff @(posedge clock) begin
    if (reset || frame_end_s) begin
      sub_y_r    <= 3'd0;
      row_base_r <= 19'd0;
    end else if (h_end_s && in_y_s) begin
      if (sub_y_r == 3'(SCALE - 1)) begin
        sub_y_r    <= 3'd0;
        row_base_r <= row_base_r + 19'(IMG_W);
      end else begin
        sub_y_r <= sub_y_r + 3'd1;
      end
    end
  end

  // Store address straight from registered counters.
  always_comb begin
    address = 19'd0;
    if (in_image_s) begin
      address = row_base_r + col_r;
    end else begin
      address = 19'd0;
    end
  end

  // Pixel colour source for stage 2, aligned with q from the store.
  always_comb begin
    pix_s = 3'b000;
    if (!active_d_r) begin
      pix_s = 3'b000;
    end else if (in_image_d_r) begin
      pix_s = q;
    end else begin
      pix_s = BG_COLOR;
    end
  end

  // Stage 1 delays timing to match store latency; stage 2 registers the pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      hs_d_r       <= 1'b1;
      vs_d_r       <= 1'b1;
      active_d_r   <= 1'b0;
      in_image_d_r <= 1'b0;
      vga_hs       <= 1'b1;
      vga_vs       <= 1'b1;
      vga_blank_n  <= 1'b0;
      vga_r        <= 8'h00;
      vga_g        <= 8'h00;
      vga_b        <= 8'h00;
    end else begin
      hs_d_r       <= hs_s;
      vs_d_r       <= vs_s;
      active_d_r   <= active_s;
      in_image_d_r <= in_image_s;
      vga_hs       <= hs_d_r;
      vga_vs       <= vs_d_r;
      vga_blank_n  <= active_d_r;
      vga_r        <= {8{pix_s[2]}};
      vga_g        <= {8{pix_s[1]}};
      vga_b        <= {8{pix_s[0]}};
    end
  end

endmodule

// File: tb/tb_image_scanner.sv
// Randomized self-checking bench for image_scanner on a shrunken raster so that
// several full frames fit in a short run; expectations come from plain arithmetic.
module tb_image_scanner;

  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 40, VFP = 2, VS = 2, VBP = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int IW = 10, IH = 8;
  localparam int SA = 3, XA = 5, YA = 6;
  localparam logic [2:0] BGA = 3'b101;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  state;
  logic [2:0]  q_a, q_b;
  logic [3:0]  image_state, image_state_b;
  logic [18:0] address, address_b;
  logic        vga_hs, vga_vs, vga_blank_n, frame_start;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        hs_b, vs_b, blank_b, fs_b;
  logic [7:0]  r_b, g_b, b_b;

  int checks = 0;
  int failures = 0;

  int   m_h, m_v;
  logic [3:0] m_img;
  bit   p1_ok, p2_ok, fs_exp;
  int   p1_h, p1_v, p2_h, p2_v;

  always #5 clock = ~clock;

  // Store models: registered read returning the address's low bits.
  always @(posedge clock) begin
    q_a <= address[2:0];
    q_b <= address_b[2:0];
  end

  image_scanner #(
    .IMG_W(IW), .IMG_H(IH), .SCALE(SA), .X0(XA), .Y0(YA), .BG_COLOR(BGA),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clock(clock), .reset(reset), .state(state), .q(q_a),
    .image_state(image_state), .address(address),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
  );

  image_scanner #(
    .IMG_W(IW), .IMG_H(IH), .SCALE(1), .X0(0), .Y0(0), .BG_COLOR(3'b000),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut_b (
    .clock(clock), .reset(reset), .state(state), .q(q_b),
    .image_state(image_state_b), .address(address_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_blank_n(blank_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .frame_start(fs_b)
  );

  function automatic bit in_img(int h, int v, int s, int x0, int y0);
    return (h >= x0) && (h < x0 + IW * s) && (v >= y0) && (v < y0 + IH * s);
  endfunction

  function automatic int ref_addr(int h, int v, int s, int x0, int y0);
    if (!in_img(h, v, s, x0, y0)) return 0;
    return ((v - y0) / s) * IW + (h - x0) / s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)", tag, obs, exp, m_h, m_v, $time);
    end
  endtask

  // One clock: advance the reference raster, then compare at the falling edge.
  task automatic tick();
    int e_hs, e_vs, e_bl, e_pix;
    @(posedge clock);
    if (reset) begin
      m_h = 0; m_v = 0; m_img = 4'd0;
      p1_ok = 1'b0; p2_ok = 1'b0; fs_exp = 1'b0;
    end else begin
      p2_ok = p1_ok; p2_h = p1_h; p2_v = p1_v;
      p1_ok = 1'b1;  p1_h = m_h;  p1_v = m_v;
      fs_exp = (m_h == HT - 1) && (m_v == VT - 1);
      if (fs_exp) m_img = state;
      m_h = m_h + 1;
      if (m_h == HT) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end
    end
    @(negedge clock);
    if (!p2_ok) begin
      e_hs = 1; e_vs = 1; e_bl = 0; e_pix = 0;
    end else begin
      e_hs  = (p2_h >= HA + HFP && p2_h < HA + HFP + HS) ? 0 : 1;
      e_vs  = (p2_v >= VA + VFP && p2_v < VA + VFP + VS) ? 0 : 1;
      e_bl  = (p2_h < HA && p2_v < VA) ? 1 : 0;
      e_pix = (e_bl == 0) ? 0 :
              in_img(p2_h, p2_v, SA, XA, YA) ? (ref_addr(p2_h, p2_v, SA, XA, YA) % 8) : int'(BGA);
    end
    chk("address", 32'(address), ref_addr(m_h, m_v, SA, XA, YA));
    chk("address_scale1", 32'(address_b), ref_addr(m_h, m_v, 1, 0, 0));
    chk("image_state", 32'(image_state), 32'(m_img));
    chk("frame_start", 32'(frame_start), 32'(fs_exp));
    chk("vga_hs", 32'(vga_hs), e_hs);
    chk("vga_vs", 32'(vga_vs), e_vs);
    chk("vga_blank_n", 32'(vga_blank_n), e_bl);
    chk("vga_r", 32'(vga_r), ((e_pix / 4) % 2 == 1) ? 32'hFF : 32'h00);
    chk("vga_g", 32'(vga_g), ((e_pix / 2) % 2 == 1) ? 32'hFF : 32'h00);
    chk("vga_b", 32'(vga_b), (e_pix % 2 == 1) ? 32'hFF : 32'h00);
  endtask

  initial begin
    int fs_cnt, hs_cnt, vs_cnt, bl_cnt;
    reset = 1'b1;
    state = 4'd0;
    repeat (4) tick();
    reset = 1'b0;

    // Frame 1: random churn early, then 9 from line 20, held to the wrap.
    while (!(m_h == HT - 1 && m_v == VT - 1)) begin
      if (m_v < 20 && $urandom_range(0, 299) == 0) state = 4'($urandom_range(0, 15));
      else if (m_v == 20 && m_h == 0) state = 4'd9;
      tick();
    end
    tick();
    chk("switch_to_9", 32'(image_state), 32'd9);

    // Frame 2: aggregate sync/blank/pulse counts, state changed at the wrap edge.
    fs_cnt = 0; hs_cnt = 0; vs_cnt = 0; bl_cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      if (m_h == HT - 1 && m_v == VT - 1) state = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 499) == 0) state = 4'($urandom_range(0, 15));
      tick();
      fs_cnt += int'(frame_start);
      hs_cnt += int'(!vga_hs);
      vs_cnt += int'(!vga_vs);
      bl_cnt += int'(vga_blank_n);
    end
    chk("frame_start_per_frame", fs_cnt, 1);
    chk("hs_low_per_frame", hs_cnt, HS * VT);
    chk("vs_low_per_frame", vs_cnt, VS * HT);
    chk("blank_high_per_frame", bl_cnt, HA * VA);

    // Mid-frame reset held for 3 cycles.
    while (!(m_h == 30 && m_v == 25)) tick();
    state = 4'd7;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("post_reset_image_state", 32'(image_state), 32'd0);
    chk("post_reset_address", 32'(address), 32'd0);

    // One more full frame with random select changes.
    for (int i = 0; i < HT * VT + 200; i++) begin
      if ($urandom_range(0, 399) == 0) state = 4'($urandom_range(0, 15));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
